// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: fetch FSM states, instruction size, reset PC.
// Pure declarations, no timing or flow-control behaviour.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    localparam int          INST_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

    // Instructions are word aligned; low address bits of a redirect are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~(32'(INST_BYTES) - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: I-cache request/response, redirect and stall inputs, IF/ID output pair.
// master = fetch unit, slave = the surrounding cache / pipeline.
interface fetch_unit_if;

    logic        stall_in;
    logic        br_mispredict;
    logic [31:0] br_target;

    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;

    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;

    modport master (
        input  stall_in, br_mispredict, br_target, inst_resp, inst_rdata,
        output inst_read, inst_addr, valid_out, pc_out, inst_out
    );

    modport slave (
        output stall_in, br_mispredict, br_target, inst_resp, inst_rdata,
        input  inst_read, inst_addr, valid_out, pc_out, inst_out
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, inst} buffer that parks a fetched pair while IF/ID is stalled.
// Loads and clears take effect on the next clock; clear wins over load.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= wr_pc;
            inst  <= wr_inst;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps the I-cache request stable until its response,
// delivers the response to IF/ID in the same cycle, parks it under stall, squashes after a redirect.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    fetch_unit_if.master    bus
);

    localparam logic [31:0] STEP  = 32'(INST_BYTES);
    localparam logic [31:0] STEP2 = 32'(2 * INST_BYTES);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_q, req_d;

    logic         hold_load, hold_clear;
    logic         hold_valid;
    logic [31:0]  hold_pc, hold_inst;

    logic [31:0]  tgt;
    logic         resp, mis, stall;

    logic         read_o, valid_o;
    logic [31:0]  pc_o, inst_o;

    assign tgt   = align_pc(bus.br_target);
    assign resp  = bus.inst_resp;
    assign mis   = bus.br_mispredict;
    assign stall = bus.stall_in;

    fetch_hold_buf u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (hold_load),
        .clear   (hold_clear),
        .wr_pc   (req_q),
        .wr_inst (bus.inst_rdata),
        .valid   (hold_valid),
        .pc      (hold_pc),
        .inst    (hold_inst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            req_q   <= RESET_PC;
            pc_q    <= RESET_PC + STEP;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pc_q    <= pc_d;
        end
    end

    // A redirect never changes req_addr while a request is open; it is parked in pc
    // and promoted only once the stale response has been swallowed.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        case (state_q)
            FETCH: begin
                if (mis) begin
                    if (resp) begin
                        req_d = tgt;
                        pc_d  = tgt + STEP;
                    end else begin
                        pc_d    = tgt;
                        state_d = SQUASH;
                    end
                end else if (resp) begin
                    if (stall) begin
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        req_d = req_q + STEP;
                        pc_d  = req_q + STEP2;
                    end
                end
            end
            HOLD: begin
                if (mis) begin
                    hold_clear = 1'b1;
                    req_d      = tgt;
                    pc_d       = tgt + STEP;
                    state_d    = FETCH;
                end else if (!stall) begin
                    hold_clear = 1'b1;
                    req_d      = hold_pc + STEP;
                    pc_d       = hold_pc + STEP2;
                    state_d    = FETCH;
                end
            end
            SQUASH: begin
                if (resp) begin
                    state_d = FETCH;
                    if (mis) begin
                        req_d = tgt;
                        pc_d  = tgt + STEP;
                    end else begin
                        req_d = pc_q;
                        pc_d  = pc_q + STEP;
                    end
                end else if (mis) begin
                    pc_d = tgt;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        read_o  = 1'b0;
        valid_o = 1'b0;
        pc_o    = '0;
        inst_o  = '0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    read_o = 1'b1;
                    if (resp && !mis) begin
                        valid_o = 1'b1;
                        pc_o    = req_q;
                        inst_o  = bus.inst_rdata;
                    end
                end
                HOLD: begin
                    if (hold_valid && !mis) begin
                        valid_o = 1'b1;
                        pc_o    = hold_pc;
                        inst_o  = hold_inst;
                    end
                end
                SQUASH:  read_o = 1'b1;
                default: read_o = 1'b0;
            endcase
        end
    end

    assign bus.inst_read = read_o;
    assign bus.inst_addr = req_q;
    assign bus.valid_out = valid_o;
    assign bus.pc_out    = pc_o;
    assign bus.inst_out  = inst_o;

    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.inst_read && !bus.inst_resp) |=> (bus.inst_read && bus.inst_addr == $past(bus.inst_addr)));

    a_no_valid_on_redirect: assert property (@(posedge clk) disable iff (rst)
        bus.br_mispredict |-> !bus.valid_out);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage: owns the program counter, drives the I-cache read handshake, and presents fetched instruction/PC pairs to the IF/ID stage register. It sits directly upstream of IF/ID. Downstream stalls are absorbed in a one-entry hold buffer. Branch-mispredict redirects take effect without violating the cache's stable-request rule; stale responses are squashed.

## Interface
- RESET_PC, 32'h0000_0060, first fetch address after reset
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall_in  in  1  IF/ID cannot accept this cycle (hazard unit)
- br_mispredict  in  1  redirect request from EX
- br_target  in  32  redirect address; bits [1:0] ignored (forced 0)
- inst_read  out  1  I-cache read request
- inst_addr  out  32  I-cache request address
- inst_resp  in  1  I-cache response valid (one-cycle pulse)
- inst_rdata  in  32  I-cache response data
- valid_out  out  1  inst_out/pc_out hold a valid instruction
- pc_out  out  32  PC of inst_out
- inst_out  out  32  instruction word

## Operation
- Registers: pc (next address to fetch), req_addr (address of the outstanding request), hold_pc, hold_inst, state.
- States:
  - FETCH: inst_read=1, inst_addr=req_addr.
  - HOLD: inst_read=0, outputs driven from the hold buffer.
  - SQUASH: inst_read=1, inst_addr=req_addr; the response to this request is discarded.
- FETCH, inst_resp=1, no mispredict, stall_in=0:
  - valid_out=1, pc_out=req_addr, inst_out=inst_rdata (combinational, same cycle).
  - Next cycle: req_addr<=req_addr+4, pc<=req_addr+8; stay in FETCH.
- FETCH, inst_resp=1, no mispredict, stall_in=1:
  - Capture the pair into the hold buffer; go to HOLD.
- HOLD:
  - valid_out=1 from the buffer.
  - When stall_in=0, the pair is consumed: req_addr<=hold_pc+4; go to FETCH.
- FETCH, inst_resp=0, no mispredict: hold inst_read and inst_addr stable; valid_out=0.
- br_mispredict has priority over all other events in every state:
  - FETCH with inst_resp=0: request still open. pc<=br_target&~3; go to SQUASH.
  - FETCH with inst_resp=1: drop the response (valid_out=0). req_addr<=target; stay in FETCH.
  - HOLD: drop the buffer (valid_out=0). req_addr<=target; go to FETCH.
  - SQUASH: pc<=newest target; stay in SQUASH until the response arrives.
- SQUASH + inst_resp (no new mispredict): discard, valid_out=0. req_addr<=pc; go to FETCH.
- SQUASH + inst_resp + mispredict in the same cycle: discard. req_addr<=new target; go to FETCH.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- valid_out is never asserted in the cycle br_mispredict=1.

## Timing
- Reset values:
  - inst_read=0, valid_out=0, pc_out=0, inst_out=0 while rst=1.
  - State FETCH, req_addr=RESET_PC, pc=RESET_PC+4.
  - First inst_read=1 in the cycle after rst deasserts.
- rst mid-request: abandon the request; the first post-reset cycle issues RESET_PC. The cache is reset with the same rst.
- Latency:
  - inst_resp to valid_out: 0 cycles.
  - Back-to-back fetch issues a new address the cycle after inst_resp. Throughput is one instruction per cache-latency+1 cycles.
- Handshake rules:
  - inst_addr must not change while inst_read=1 and inst_resp has not yet pulsed.
  - inst_read drops only in HOLD or under reset.
- Redirect penalty:
  - 1 cycle if no request is open.
  - Remaining cache latency + 1 if in SQUASH.

## Structure
- Shared package pipeline_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {FETCH, HOLD, SQUASH}
  - localparam INST_BYTES = 4
  - The RESET_PC default constant.
- One sub-module, fetch_hold_buf: one-entry {pc,inst} buffer with load/clear/valid. The FSM, pc and req_addr stay in fetch_unit.

## Test plan
- Reset then 1-cycle cache: rst high 3 cycles, released.
  - inst_addr=0x60 next cycle.
  - Responses 0x13,0x93,0x113 → valid_out pairs (0x60,0x13),(0x64,0x93),(0x68,0x113).
- Stall: stall_in=1 for 4 cycles when the response for 0x64 arrives.
  - inst_read=0 during the stall; valid_out=1 with (0x64,data) throughout.
  - stall_in=0 → next inst_addr=0x68.
- Mispredict mid-wait: 3-cycle cache, br_mispredict with target 0x200 one cycle after 0x70 is issued.
  - inst_addr stays 0x70 until resp; that response is not output.
  - Next inst_addr=0x200.
- Mispredict coincident with resp (target 0x301): valid_out=0 that cycle; next inst_addr=0x300.
- Double mispredict in SQUASH (targets 0x400 then 0x500): after resp, inst_addr=0x500.
- Wrap: redirect to 0xFFFF_FFFC; after its response, inst_addr=0x0000_0000.
